cabac_bypass_decoder_seq: RTL

// - Sequential, parametrised multi-bin CABAC bypass (equiprobable) decoder for the VVC arithmetic decoder.
// - Owns the offset register m_value and a bit buffer fed by a bitstream byte stream.
// - Decodes 1..MAX_BINS bypass bins per request in a single cycle; refills its own bits.
// - Sits between the bitstream byte FIFO and the syntax-element FSM; context-coded bins are out of scope.

---
 rtl/cabac_bypass_decoder_seq_pkg.sv | 22 ++
 rtl/cabac_bypass_decoder_seq_bin_step.sv | 28 ++
 rtl/cabac_bypass_decoder_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cabac_bypass_decoder_seq_pkg.sv
// Shared constants, FSM encoding and helpers for the CABAC bypass decoder.
package cabac_bypass_decoder_seq_pkg;

   localparam int SCALE_SHIFT = 7;
   localparam int VALUE_W     = 16;
   localparam int RANGE_W     = 9;
   localparam logic [RANGE_W-1:0] MIN_RANGE = 9'd256;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READY = 3'd2,
      ST_STALL = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   // m_range aligned to the 16-bit offset register.
   function automatic logic [VALUE_W-1:0] scale_range(input logic [RANGE_W-1:0] range);
      scale_range = {range, {SCALE_SHIFT{1'b0}}};
   endfunction

endpackage

// File: rtl/cabac_bypass_decoder_seq_bin_step.sv
// One equiprobable bin: shift one stream bit into the offset and compare with scaledRange.
module cabac_bypass_decoder_seq_bin_step
   import cabac_bypass_decoder_seq_pkg::*;
(
   input  logic [VALUE_W-1:0] value_in,
   input  logic [VALUE_W-1:0] scaled_range,
   input  logic               bit_in,
   output logic [VALUE_W-1:0] value_next,
   output logic               bin
);

   logic [VALUE_W:0] t_s;
   logic [VALUE_W:0] diff_s;

   // Compare and conditionally subtract; t is one bit wider than the offset.
   always_comb begin
      t_s    = {value_in, bit_in};
      diff_s = t_s - {1'b0, scaled_range};
      if (t_s >= {1'b0, scaled_range}) begin
         bin        = 1'b1;
         value_next = diff_s[VALUE_W-1:0];
      end else begin
         bin        = 1'b0;
         value_next = t_s[VALUE_W-1:0];
      end
   end

endmodule

// File: rtl/cabac_bypass_decoder_seq.sv
// Sequential multi-bin CABAC bypass decoder: owns m_value and a byte-fed bit buffer,
// decodes 1..MAX_BINS equiprobable bins per accepted request.
module cabac_bypass_decoder_seq
   import cabac_bypass_decoder_seq_pkg::*;
#(
   parameter int MAX_BINS = 4,
   parameter int BUF_BITS = 32
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           init,
   input  logic [7:0]                     s_byte,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [$clog2(MAX_BINS+1)-1:0]  req_nbins,
   input  logic [RANGE_W-1:0]             req_range,
   output logic                           bin_valid,
   input  logic                           bin_ready,
   output logic [MAX_BINS-1:0]            bin_out,
   output logic [$clog2(MAX_BINS+1)-1:0]  bin_count,
   output logic [VALUE_W-1:0]             value_out,
   output logic                           err_range
);

   localparam int NB_W  = $clog2(MAX_BINS+1);
   localparam int CNT_W = $clog2(BUF_BITS+1);

   state_t                         state_r;
   logic [BUF_BITS-1:0]            buf_r;
   logic [CNT_W-1:0]               bit_cnt_r;
   logic [VALUE_W-1:0]             value_r;
   logic [NB_W-1:0]                nbins_r;
   logic [RANGE_W-1:0]             range_r;
   logic                           bin_valid_r;
   logic [MAX_BINS-1:0]            bin_out_r;
   logic [NB_W-1:0]                bin_count_r;
   logic                           err_r;

   logic [NB_W-1:0]                req_nbins_s;
   logic [NB_W-1:0]                dec_nbins_s;
   logic [RANGE_W-1:0]             dec_range_s;
   logic [VALUE_W-1:0]             scaled_s;
   logic [MAX_BINS:0][VALUE_W-1:0] val_chain_s;
   logic [MAX_BINS-1:0]            bins_s;
   logic [MAX_BINS-1:0]            bin_field_s;
   logic [VALUE_W-1:0]             val_commit_s;
   logic                           bits_ok_s;
   logic                           req_fire_s;
   logic                           do_load_s;
   logic                           do_decode_s;
   logic                           byte_acc_s;
   logic                           range_bad_s;
   logic [CNT_W-1:0]               consume_s;
   logic [CNT_W-1:0]               remain_s;
   logic [BUF_BITS-1:0]            base_buf_s;
   logic [BUF_BITS-1:0]            buf_next_s;
   logic [CNT_W-1:0]               cnt_next_s;

   assign s_ready    = (state_r != ST_IDLE) && (bit_cnt_r <= CNT_W'(BUF_BITS - 8));
   assign req_ready  = (state_r == ST_READY) && !init;
   assign req_fire_s = req_valid && req_ready;
   assign byte_acc_s = s_valid && s_ready;

   assign bin_valid  = bin_valid_r;
   assign bin_out    = bin_out_r;
   assign bin_count  = bin_count_r;
   assign value_out  = value_r;
   assign err_range  = err_r;

   // Out-of-range bin counts decode a single bin; STALL replays the latched request.
   always_comb begin
      if ((req_nbins == '0) || (req_nbins > NB_W'(MAX_BINS))) begin
         req_nbins_s = NB_W'(1'b1);
      end else begin
         req_nbins_s = req_nbins;
      end
      if (state_r == ST_STALL) begin
         dec_nbins_s = nbins_r;
         dec_range_s = range_r;
      end else begin
         dec_nbins_s = req_nbins_s;
         dec_range_s = req_range;
      end
   end

   assign scaled_s       = scale_range(dec_range_s);
   assign val_chain_s[0] = value_r;

   genvar gi;
   generate
      for (gi = 0; gi < MAX_BINS; gi++) begin : g_step
         cabac_bypass_decoder_seq_bin_step u_step (
            .value_in     (val_chain_s[gi]),
            .scaled_range (scaled_s),
            .bit_in       (buf_r[BUF_BITS-1-gi]),
            .value_next   (val_chain_s[gi+1]),
            .bin          (bins_s[MAX_BINS-1-gi])
         );
      end
   endgenerate

   // Only the first dec_nbins stages commit; first bin ends up in the MSB of the used field.
   always_comb begin
      bin_field_s  = bins_s >> (MAX_BINS - int'(dec_nbins_s));
      val_commit_s = val_chain_s[dec_nbins_s];
      bits_ok_s    = bit_cnt_r >= CNT_W'(dec_nbins_s);
      range_bad_s  = (req_range < MIN_RANGE) || (value_r >= scale_range(req_range));
      do_load_s    = (state_r == ST_LOAD) && !init && (bit_cnt_r >= CNT_W'(VALUE_W));
      do_decode_s  = (req_fire_s && bits_ok_s) ||
                     ((state_r == ST_STALL) && !init && bits_ok_s);
   end

   // Bit buffer is MSB-aligned: consume shifts left, new bytes land below remaining bits.
   always_comb begin
      if (do_load_s) begin
         consume_s = CNT_W'(VALUE_W);
      end else if (do_decode_s) begin
         consume_s = CNT_W'(dec_nbins_s);
      end else begin
         consume_s = '0;
      end
      if (init) begin
         base_buf_s = '0;
         remain_s   = '0;
      end else begin
         base_buf_s = buf_r << consume_s;
         remain_s   = bit_cnt_r - consume_s;
      end
      if (byte_acc_s) begin
         buf_next_s = base_buf_s | ({s_byte, {(BUF_BITS-8){1'b0}}} >> remain_s);
         cnt_next_s = remain_s + CNT_W'(8);
      end else begin
         buf_next_s = base_buf_s;
         cnt_next_s = remain_s;
      end
   end

   // Control FSM with registered result, offset and sticky range error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         buf_r       <= '0;
         bit_cnt_r   <= '0;
         value_r     <= '0;
         nbins_r     <= '0;
         range_r     <= '0;
         bin_valid_r <= 1'b0;
         bin_out_r   <= '0;
         bin_count_r <= '0;
         err_r       <= 1'b0;
      end else begin
         buf_r     <= buf_next_s;
         bit_cnt_r <= cnt_next_s;
         if (req_fire_s && range_bad_s) begin
            err_r <= 1'b1;
         end
         if (init) begin
            state_r     <= ST_LOAD;
            bin_valid_r <= 1'b0;
            bin_out_r   <= '0;
            bin_count_r <= '0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_IDLE;
               end
               ST_LOAD: begin
                  if (do_load_s) begin
                     value_r <= buf_r[BUF_BITS-1 -: VALUE_W];
                     state_r <= ST_READY;
                  end
               end
               ST_READY: begin
                  if (req_fire_s) begin
                     nbins_r <= req_nbins_s;
                     range_r <= req_range;
                     if (bits_ok_s) begin
                        value_r     <= val_commit_s;
                        bin_out_r   <= bin_field_s;
                        bin_count_r <= dec_nbins_s;
                        bin_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                     end else begin
                        state_r <= ST_STALL;
                     end
                  end
               end
               ST_STALL: begin
                  if (bits_ok_s) begin
                     value_r     <= val_commit_s;
                     bin_out_r   <= bin_field_s;
                     bin_count_r <= dec_nbins_s;
                     bin_valid_r <= 1'b1;
                     state_r     <= ST_OUT;
                  end
               end
               ST_OUT: begin
                  if (bin_ready) begin
                     bin_valid_r <= 1'b0;
                     state_r     <= ST_READY;
                  end
               end
               default: begin
                  state_r     <= ST_IDLE;
                  bin_valid_r <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
